// File: rtl/ram_arbiter_2port_if.sv
// ram_arbiter_2port_if: requester A/B handshake and RAM bus shared by ram_arbiter_2port
// slave modport is the arbiter side, master modport is the requester/RAM side.
// Per requester x in {a,b}: i_req_x, i_write_x, i_addr_x, i_data_x in; o_ack_x, o_data_x out.
// RAM side: o_ram_addr, o_ram_enable_x, o_ram_write_x, o_ram_data out; i_ram_data in. Status: o_busy.
interface ram_arbiter_2port_if #(
  parameter int addr_width = 16,
  parameter int data_width = 8
);
  logic                  i_req_a, i_write_a, o_ack_a;
  logic [addr_width-1:0] i_addr_a;
  logic [data_width-1:0] i_data_a, o_data_a;
  logic                  i_req_b, i_write_b, o_ack_b;
  logic [addr_width-1:0] i_addr_b;
  logic [data_width-1:0] i_data_b, o_data_b;
  logic [addr_width-1:0] o_ram_addr;
  logic                  o_ram_enable_x, o_ram_write_x, o_busy;
  logic [data_width-1:0] o_ram_data, i_ram_data;
  modport slave (
    input  i_req_a, i_write_a, i_addr_a, i_data_a, i_req_b, i_write_b, i_addr_b, i_data_b, i_ram_data,
    output o_ack_a, o_data_a, o_ack_b, o_data_b, o_ram_addr, o_ram_enable_x, o_ram_write_x, o_ram_data, o_busy
  );
  modport master (
    output i_req_a, i_write_a, i_addr_a, i_data_a, i_req_b, i_write_b, i_addr_b, i_data_b, i_ram_data,
    input  o_ack_a, o_data_a, o_ack_b, o_data_b, o_ram_addr, o_ram_enable_x, o_ram_write_x, o_ram_data, o_busy
  );
endinterface

// File: rtl/ram_arbiter_2port.sv
// ram_arbiter_2port: serialises two request/ack ports onto one RAM, one access per IDLE->ACCESS->DONE pass
// Ports: clk, rst_x (synchronous, active-low), bus (ram_arbiter_2port_if.slave: both requesters + RAM + busy).
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise A has fixed priority.
module ram_arbiter_2port #(
  parameter int addr_width = 16,
  parameter int data_width = 8
) (
  input  logic               clk,
  input  logic               rst_x,
  ram_arbiter_2port_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic any_req, pick_b, gnt_b, win_write;
  logic [addr_width-1:0] win_addr;
  logic [data_width-1:0] win_data;
  assign any_req = bus.i_req_a || bus.i_req_b;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  logic last_b;
  assign pick_b = bus.i_req_b && (!bus.i_req_a || !last_b);
`else
  assign pick_b = bus.i_req_b && !bus.i_req_a;
`endif
  assign win_addr  = pick_b ? bus.i_addr_b : bus.i_addr_a;
  assign win_data  = pick_b ? bus.i_data_b : bus.i_data_a;
  assign win_write = pick_b ? bus.i_write_b : bus.i_write_a;
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE ? (any_req ? ACCESS : IDLE) : state == ACCESS ? DONE : IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_x) state <= IDLE;
    else state <= state_n;
  // Strobes, ack and busy are computed from the next state so every output is a plain register.
  always_ff @(posedge clk) begin
    if (!rst_x) begin
      bus.o_ram_enable_x <= 1'b1;
      bus.o_ram_write_x  <= 1'b1;
      bus.o_ram_addr     <= '0;
      bus.o_ram_data     <= '0;
      bus.o_ack_a        <= 1'b0;
      bus.o_ack_b        <= 1'b0;
      bus.o_data_a       <= '0;
      bus.o_data_b       <= '0;
      bus.o_busy         <= 1'b0;
      gnt_b              <= 1'b0;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
      last_b             <= 1'b1;
`endif
    end else begin
      bus.o_ram_enable_x <= state_n != ACCESS;
      bus.o_ram_write_x  <= !(state_n == ACCESS && win_write);
      bus.o_busy         <= state_n != IDLE;
      bus.o_ack_a        <= state == ACCESS && !gnt_b;
      bus.o_ack_b        <= state == ACCESS && gnt_b;
      if (state == IDLE && any_req) begin
        gnt_b          <= pick_b;
        bus.o_ram_addr <= win_addr;
        bus.o_ram_data <= win_data;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        last_b         <= pick_b;
`endif
      end
      // write_x still high in ACCESS marks a read; capture the RAM output at the end of that cycle
      if (state == ACCESS && bus.o_ram_write_x) begin
        if (gnt_b) bus.o_data_b <= bus.i_ram_data;
        else bus.o_data_a <= bus.i_ram_data;
      end
    end
  end
endmodule

// File: tb/tb_ram_arbiter_2port.sv
// tb_ram_arbiter_2port: scoreboard bench for ram_arbiter_2port with a behavioural 64Kx8 RAM
module tb_ram_arbiter_2port;
  logic clk = 1'b0;
  logic rst_x = 1'b0;
  always #5 clk = ~clk;
  ram_arbiter_2port_if #(.addr_width(16), .data_width(8)) bus ();
  ram_arbiter_2port #(.addr_width(16), .data_width(8)) dut (.clk(clk), .rst_x(rst_x), .bus(bus.slave));
  logic [7:0] mem [0:65535];
  assign bus.i_ram_data = mem[bus.o_ram_addr];
  always @(posedge clk) if (!bus.o_ram_enable_x && !bus.o_ram_write_x) mem[bus.o_ram_addr] <= bus.o_ram_data;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] shadow [int];
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  logic [7:0] exp_da = 8'h00;
  logic [7:0] exp_db = 8'h00;
  logic prev_low = 1'b0;
  // enable must never stay low two cycles in a row, and write strobe only together with enable
  always @(negedge clk) begin
    if (!bus.o_ram_enable_x || !bus.o_ram_write_x) begin
      n_cmp++;
      if (prev_low || bus.o_ram_enable_x) begin
        n_err++;
        $display("FAIL strobe_pulse: enable_x=%b write_x=%b prev_low=%b want single-cycle enable", bus.o_ram_enable_x, bus.o_ram_write_x, prev_low);
      end
    end
    prev_low = !bus.o_ram_enable_x;
  end
  task automatic issue(input logic b, input logic w, input logic [15:0] a, input logic [7:0] d);
    if (w) shadow[a] = d;
    if (b) begin
      bus.i_req_b = 1'b1; bus.i_write_b = w; bus.i_addr_b = a; bus.i_data_b = d;
      if (!w) exp_db = shadow[a];
      qb.push_back(exp_db);
    end else begin
      bus.i_req_a = 1'b1; bus.i_write_a = w; bus.i_addr_a = a; bus.i_data_a = d;
      if (!w) exp_da = shadow[a];
      qa.push_back(exp_da);
    end
  endtask
  task automatic access(input logic b, input logic w, input logic [15:0] a, input logic [7:0] d,
                        output int cyc, output int n_low, output logic [7:0] got, output logic [7:0] want);
    @(posedge clk); #1;
    issue(b, w, a, d);
    cyc = 0;
    n_low = 0;
    do begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (!bus.o_ram_enable_x) n_low++;
    end while (!(b ? bus.o_ack_b : bus.o_ack_a) && cyc < 12);
    got = b ? bus.o_data_b : bus.o_data_a;
    want = b ? qb.pop_front() : qa.pop_front();
    @(posedge clk); #1;
    if (b) bus.i_req_b = 1'b0; else bus.i_req_a = 1'b0;
  endtask
  task automatic test_reset;
    rst_x = 1'b0;
    bus.i_req_a = 1'b1; bus.i_write_a = 1'b1; bus.i_addr_a = 16'h1234; bus.i_data_a = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.o_ram_enable_x, bus.o_ram_write_x, bus.o_ack_a, bus.o_ack_b, bus.o_busy} !== 5'b11000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 11000", {bus.o_ram_enable_x, bus.o_ram_write_x, bus.o_ack_a, bus.o_ack_b, bus.o_busy});
    end
    n_cmp++;
    if ({bus.o_ram_addr, bus.o_ram_data, bus.o_data_a, bus.o_data_b} !== 40'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", {bus.o_ram_addr, bus.o_ram_data, bus.o_data_a, bus.o_data_b});
    end
    bus.i_req_a = 1'b0;
    rst_x = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.o_ram_enable_x, bus.o_busy} !== 2'b10) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b want 10", {bus.o_ram_enable_x, bus.o_busy});
    end
  endtask
  task automatic test_write_read_a;
    int cyc, n_low;
    logic [7:0] got, want;
    for (int i = 0; i < 2; i++) begin
      access(1'b0, i == 0, 16'h1234, 8'h5A, cyc, n_low, got, want);
      n_cmp++;
      if (cyc != 2 || n_low != 1) begin
        n_err++;
        $display("FAIL wr_rd_a_timing[%0d]: got ack at %0d, %0d enable cycles want 2, 1", i, cyc, n_low);
      end
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL wr_rd_a_data[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask
  task automatic test_tie;
    int cyc, n_low, t, last, n;
    logic [7:0] got, want, cur_a, cur_b;
    logic e;
    logic order [$];
    access(1'b0, 1'b1, 16'h0000, 8'h11, cyc, n_low, got, want);
    access(1'b1, 1'b1, 16'hFFFF, 8'h22, cyc, n_low, got, want);
    n_cmp++;
    if (cyc != 2 || got !== want) begin
      n_err++;
      $display("FAIL write_b: got ack at %0d data %h want 2 %h", cyc, got, want);
    end
    @(posedge clk); #1 rst_x = 1'b0;
    @(posedge clk); #1 rst_x = 1'b1;
    exp_da = 8'h00;
    exp_db = 8'h00;
    cur_a = 8'h00;
    cur_b = 8'h00;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, 1'b0, 16'h0000, 8'h00);
      issue(1'b1, 1'b0, 16'hFFFF, 8'h00);
      order.push_back(1'b0);
      order.push_back(1'b1);
    end
`else
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b0, 16'h0000, 8'h00);
      order.push_back(1'b0);
    end
    bus.i_req_b = 1'b1; bus.i_write_b = 1'b0; bus.i_addr_b = 16'hFFFF; bus.i_data_b = 8'h00;
`endif
    t = 0;
    last = 0;
    n = 0;
    while (n < 4 && t < 30) begin
      @(posedge clk); t++;
      @(negedge clk);
      if (bus.o_ack_a || bus.o_ack_b) begin
        e = order.pop_front();
        want = e ? qb.pop_front() : qa.pop_front();
        got = e ? bus.o_data_b : bus.o_data_a;
        n_cmp++;
        if ({bus.o_ack_a, bus.o_ack_b} !== (e ? 2'b01 : 2'b10)) begin
          n_err++;
          $display("FAIL tie_grant[%0d]: got ack_a/ack_b %b want %b", n, {bus.o_ack_a, bus.o_ack_b}, e ? 2'b01 : 2'b10);
        end
        n_cmp++;
        if (got !== want) begin
          n_err++;
          $display("FAIL tie_data[%0d]: got %h want %h", n, got, want);
        end
        n_cmp++;
        if ((e ? bus.o_data_a : bus.o_data_b) !== (e ? cur_a : cur_b)) begin
          n_err++;
          $display("FAIL tie_other_hold[%0d]: got %h want %h", n, e ? bus.o_data_a : bus.o_data_b, e ? cur_a : cur_b);
        end
        n_cmp++;
        if (t - last != (n == 0 ? 2 : 3)) begin
          n_err++;
          $display("FAIL tie_spacing[%0d]: got %0d cycles want %0d", n, t - last, n == 0 ? 2 : 3);
        end
        if (e) cur_b = want; else cur_a = want;
        last = t;
        n++;
      end
    end
    n_cmp++;
    if (n != 4) begin
      n_err++;
      $display("FAIL tie_timeout: got %0d acks want 4", n);
    end
    bus.i_req_a = 1'b0;
    bus.i_req_b = 1'b0;
    qa.delete();
    qb.delete();
  endtask
  task automatic test_reset_mid;
    int cyc, n_low;
    logic [7:0] got, want;
    exp_da = 8'h00;
    exp_db = 8'h00;
    @(posedge clk); #1;
    issue(1'b1, 1'b1, 16'h0042, 8'h77);
    @(posedge clk); #1 rst_x = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.o_ram_enable_x, bus.o_ram_write_x} !== 2'b00) begin
      n_err++;
      $display("FAIL mid_access_strobes: got %b want 00", {bus.o_ram_enable_x, bus.o_ram_write_x});
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.o_ram_enable_x, bus.o_ram_write_x, bus.o_ack_b, bus.o_busy} !== 4'b1100) begin
      n_err++;
      $display("FAIL mid_reset_abort: got %b want 1100", {bus.o_ram_enable_x, bus.o_ram_write_x, bus.o_ack_b, bus.o_busy});
    end
    rst_x = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end while (!bus.o_ack_b && cyc < 12);
    want = qb.pop_front();
    n_cmp++;
    if (cyc != 2 || bus.o_data_b !== want) begin
      n_err++;
      $display("FAIL retry_b: got ack at %0d data %h want 2 %h", cyc, bus.o_data_b, want);
    end
    @(posedge clk); #1 bus.i_req_b = 1'b0;
    access(1'b0, 1'b0, 16'h0042, 8'h00, cyc, n_low, got, want);
    n_cmp++;
    if (cyc != 2 || got !== want) begin
      n_err++;
      $display("FAIL retry_readback: got ack at %0d data %h want 2 %h", cyc, got, want);
    end
  endtask
  task automatic test_back_to_back;
    int cyc, n_low, t, n;
    int at [2];
    logic [7:0] got, want;
    logic changed;
    access(1'b0, 1'b1, 16'h0001, 8'h5C, cyc, n_low, got, want);
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 16'h0000, 8'h00);
    t = 0;
    n = 0;
    changed = 1'b0;
    at[0] = 0;
    at[1] = 0;
    while (n < 2 && t < 20) begin
      @(posedge clk); t++;
      if (n == 1 && !changed) begin
        #1 issue(1'b0, 1'b0, 16'h0001, 8'h00);
        changed = 1'b1;
      end
      @(negedge clk);
      if (bus.o_ack_a) begin
        want = qa.pop_front();
        n_cmp++;
        if (bus.o_data_a !== want) begin
          n_err++;
          $display("FAIL b2b_data[%0d]: got %h want %h", n, bus.o_data_a, want);
        end
        at[n] = t;
        n++;
      end
    end
    n_cmp++;
    if (at[0] != 2 || at[1] != 5) begin
      n_err++;
      $display("FAIL b2b_timing: got acks at %0d,%0d want 2,5", at[0], at[1]);
    end
    @(posedge clk); #1 bus.i_req_a = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    bus.i_req_a = 1'b0; bus.i_write_a = 1'b0; bus.i_addr_a = '0; bus.i_data_a = '0;
    bus.i_req_b = 1'b0; bus.i_write_b = 1'b0; bus.i_addr_b = '0; bus.i_data_b = '0;
    test_reset;
    test_write_read_a;
    test_tie;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_arbiter_2port.md
# ram_arbiter_2port

Two-port arbiter that shares a single 64K×8 RAM (active-low enable and write strobes, combinational read data) between requesters A and B, typically the CPU and a video or DMA engine. Each requester uses a request/acknowledge handshake. The arbiter serialises accesses, drives the RAM strobes for exactly one cycle per access, and returns registered read data with a one-cycle acknowledge pulse. It sits between the requesters and the RAM instance.

## Interface
Parameters:
- addr_width, 16, RAM address width
- data_width, 8, RAM data width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_x  in  1  synchronous, active-low reset
- i_req_a  in  1  requester A access request; level, held until o_ack_a
- i_write_a  in  1  A: 1 = write, 0 = read
- i_addr_a  in  addr_width  A address
- i_data_a  in  data_width  A write data
- o_ack_a  out  1  A completion pulse, one cycle
- o_data_a  out  data_width  A read data, registered
- i_req_b, i_write_b, i_addr_b, i_data_b, o_ack_b, o_data_b: same as A, for requester B
- o_ram_addr  out  addr_width  to RAM i_addr
- o_ram_enable_x  out  1  to RAM i_enable_x, active-low
- o_ram_write_x  out  1  to RAM i_write_x, active-low
- o_ram_data  out  data_width  to RAM i_data
- i_ram_data  in  data_width  from RAM o_data
- o_busy  out  1  high in ACCESS and DONE

## Operation
- State machine with three states: IDLE → ACCESS → DONE → IDLE.
- IDLE:
  - If any i_req is high at the clock edge, select a winner.
  - Latch the winner's addr, data and write flags into the RAM output registers, and latch the grant ID.
  - Go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - o_ram_enable_x = 0.
  - o_ram_write_x = 0 only for a write.
  - Address and data are stable for the whole cycle.
  - On a read, i_ram_data is captured into the granted port's o_data at the end of the cycle.
  - Go to DONE.
- DONE:
  - Strobes return high.
  - The granted port's o_ack is 1 for this cycle only.
  - Go to IDLE.
- Requester rules:
  - Inputs must be held stable from request until the o_ack cycle, inclusive.
  - i_req still high in the cycle after o_ack counts as a new request.
- o_data_x holds its value until the next read completes on that port. Writes never change o_data_x.
- Simultaneous requests in IDLE are resolved per Configuration. The losing request stays pending and is served on the next pass through IDLE.
- A request that appears during ACCESS or DONE is sampled only in IDLE.
- Reset mid-transaction:
  - FSM goes to IDLE.
  - Strobes go high immediately (registered, at the next edge).
  - No ack is issued and the transaction is dropped; the requester must re-request.
  - A write whose ACCESS cycle has completed is already committed.

## Timing
- Reset values:
  - o_ram_enable_x = 1, o_ram_write_x = 1
  - o_ram_addr = 0, o_ram_data = 0
  - o_ack_a = o_ack_b = 0
  - o_data_a = o_data_b = 0
  - o_busy = 0
  - round-robin pointer = "last granted B"
- Latency: request sampled at edge N; ACCESS in cycle N+1; o_ack and valid o_data in cycle N+2.
- Throughput: one access per 3 cycles. Sustained throughput across both ports is 1/3 per cycle.
- Worst-case wait under contention with round-robin: one foreign access, i.e. ack 5 cycles after request.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- RAM_ARBITER_ROUND_ROBIN_EN defined:
  - On a tie, grant the port not granted last.
  - The pointer updates on every grant.
  - After reset, A wins the first tie.
- Not defined: fixed priority. A always wins a tie, B can starve, and no pointer register is built.

## Test plan
- Reset: hold rst_x = 0 for 2 cycles with i_req_a = 1 → all outputs at reset values, no ack, enable_x = 1.
- Single write then read, A: write 0x5A to 0x1234, then read 0x1234 → enable_x low exactly 1 cycle per access; o_ack_a 2 cycles after each request sample; o_data_a = 0x5A.
- Tie, round-robin: both request continuously; A reads 0x0000 and B reads 0xFFFF → grants A, B, A, B; each ack 3 cycles apart; o_data_b unchanged by A's accesses.
- Tie, macro undefined: same stimulus → A granted every pass; o_ack_b never asserts while i_req_a is held.
- Reset mid-operation: drop rst_x during the ACCESS cycle of B's write of 0x77 → next cycle IDLE, strobes high, no o_ack_b; a subsequent retry completes normally.
- Back-to-back: A holds i_req_a through the ack and changes the address to 0x0001 → second access starts in the cycle after DONE; two acks exactly 3 cycles apart.
